// File: rtl/pb_operand_loader_if.sv
// Pushbutton operand loader bus.
// Carries the raw pushbuttons, switch word and clear request into the loader,
// and the press pulses, flattened operand bus and status flags back out.
//   pb        raw pushbuttons, bit k = PB(k+1)
//   y         switch operand word
//   clear     synchronous request to empty all slots
//   pb_pulse  one-cycle debounced press pulses
//   op_bus    slot k at bits [OP_W*k +: OP_W]
//   loaded    per-slot loaded flags
//   all_valid all five slots loaded
//   err_order sticky out-of-order press flag
interface pb_operand_loader_if #(
    parameter int unsigned OP_W = 4
);
    logic [4:0]        pb;
    logic [OP_W-1:0]   y;
    logic              clear;
    logic [4:0]        pb_pulse;
    logic [5*OP_W-1:0] op_bus;
    logic [4:0]        loaded;
    logic              all_valid;
    logic              err_order;

    modport master (
        output pb, y, clear,
        input  pb_pulse, op_bus, loaded, all_valid, err_order
    );

    modport slave (
        input  pb, y, clear,
        output pb_pulse, op_bus, loaded, all_valid, err_order
    );
endinterface

// File: rtl/pb_operand_loader.sv
// Front-end for the five-pushbutton adder: synchronises and debounces the
// pushbuttons, turns debounced rising edges into one-cycle pulses, and loads
// the switch word into operand slots in PB1..PB5 order.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  pb_operand_loader_if slave modport (see interface header)
module pb_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OP_W            = 4
) (
    input  logic                clk,
    input  logic                rst,
    pb_operand_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT1 = 3'd0,
        WAIT2 = 3'd1,
        WAIT3 = 3'd2,
        WAIT4 = 3'd3,
        WAIT5 = 3'd4,
        FULL  = 3'd5
    } state_t;

    // Counter value at which the next differing sample flips the level.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t            state, state_n;
    logic [4:0]        sync1, sync2, level, level_d, pulse_q;
    logic [7:0]        cnt [5];
    logic [5*OP_W-1:0] op_q;
    logic [4:0]        loaded_q;
    logic              all_valid_q, err_q;

    logic [2:0]        idx;
    logic [4:0]        exp_mask;
    logic              accept, bad;

    // Synchroniser, debouncer and rising-edge pulse generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            pulse_q <= '0;
            for (int unsigned k = 0; k < 5; k++) cnt[k] <= '0;
        end else begin
            sync1   <= bus.pb;
            sync2   <= sync1;
            level_d <= level;
            pulse_q <= level & ~level_d;
            for (int unsigned k = 0; k < 5; k++) begin
                if (sync2[k] == level[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    level[k] <= ~level[k];
                    cnt[k]   <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) state <= WAIT1;
        else                  state <= state_n;
    end

    // WAITn encodes n-1, so the state value is also the expected slot index.
    always_comb begin
        state_n  = state;
        idx      = state;
        exp_mask = '0;
        if (state != FULL) exp_mask = 5'b00001 << idx;
        accept   = |(pulse_q & exp_mask);
        bad      = |(pulse_q & ~exp_mask);
        if (accept) state_n = state_t'(idx + 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            op_q        <= '0;
            loaded_q    <= '0;
            all_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                op_q[OP_W*idx +: OP_W] <= bus.y;
                loaded_q[idx]          <= 1'b1;
                if (state == WAIT5) all_valid_q <= 1'b1;
            end
            if (bad) err_q <= 1'b1;
        end
    end

    assign bus.pb_pulse  = pulse_q;
    assign bus.op_bus    = op_q;
    assign bus.loaded    = loaded_q;
    assign bus.all_valid = all_valid_q;
    assign bus.err_order = err_q;

endmodule

// File: tb/tb_pb_operand_loader.sv
// Self-checking bench for pb_operand_loader with DEBOUNCE_CYCLES=4, OP_W=4.
// A cycle-accurate vector table covers a clean press, hold, release and a
// bouncy press; hand-written sequences cover ordering, FULL, clear and reset.
module tb_pb_operand_loader;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pb_operand_loader_if #(.OP_W(4)) bus ();

    pb_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .OP_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  pb;
        logic [3:0]  y;
        logic [4:0]  pulse;
        logic [4:0]  loaded;
        logic [19:0] op;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [4:0] pb, input logic [3:0] y,
                                input logic [4:0] pulse, input logic [4:0] loaded,
                                input logic [19:0] op);
        vec_t v;
        v.pb = pb; v.y = y; v.pulse = pulse; v.loaded = loaded; v.op = op;
        tbl.push_back(v);
    endfunction

    // Ticks until any pulse appears, at most 20 cycles; returns ticks used.
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.pb_pulse == 5'b0 && n < 20);
    endtask

    // Press a button mask from rest, check pulse latency and value, let the
    // capture edge pass, then release and wait out the debounced release.
    task automatic press(input logic [4:0] mask, input logic [3:0] yv);
        int n;
        bus.pb = mask;
        bus.y  = yv;
        wait_pulse(n);
        chk("press_latency", n, 7);
        chk("press_pulse", bus.pb_pulse, mask);
        tick();
        bus.pb = '0;
        repeat (8) tick();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst       = 1'b1;
        bus.pb    = '0;
        bus.y     = '0;
        bus.clear = 1'b0;
        tick();
        tick();
        chk("rst_pulse",     bus.pb_pulse,  0);
        chk("rst_op",        bus.op_bus,    0);
        chk("rst_loaded",    bus.loaded,    0);
        chk("rst_all_valid", bus.all_valid, 0);
        chk("rst_err",       bus.err_order, 0);
        rst = 1'b0;

        // Record i inputs are sampled at table edge i; outputs checked after it.
        for (int i = 1; i <= 10; i++)
            add(5'b00001, 4'h8, (i == 7) ? 5'b00001 : 5'b0,
                (i >= 8) ? 5'b00001 : 5'b0, (i >= 8) ? 20'h00008 : 20'h0);
        for (int i = 11; i <= 17; i++)
            add(5'b0, 4'h8, 5'b0, 5'b00001, 20'h00008);
        for (int i = 18; i <= 21; i++)
            add((i % 2 == 0) ? 5'b00010 : 5'b0, 4'h5, 5'b0, 5'b00001, 20'h00008);
        for (int i = 22; i <= 30; i++)
            add(5'b00010, 4'h5, (i == 28) ? 5'b00010 : 5'b0,
                (i >= 29) ? 5'b00011 : 5'b00001, (i >= 29) ? 20'h00058 : 20'h00008);

        foreach (tbl[i]) begin
            bus.pb = tbl[i].pb;
            bus.y  = tbl[i].y;
            tick();
            chk($sformatf("vec%0d_pulse", i + 1),  bus.pb_pulse,  tbl[i].pulse);
            chk($sformatf("vec%0d_loaded", i + 1), bus.loaded,    tbl[i].loaded);
            chk($sformatf("vec%0d_op", i + 1),     bus.op_bus,    tbl[i].op);
            chk($sformatf("vec%0d_valid", i + 1),  bus.all_valid, 0);
            chk($sformatf("vec%0d_err", i + 1),    bus.err_order, 0);
        end
        bus.pb = '0;
        repeat (8) tick();

        // Complete the sequence PB3..PB5.
        press(5'b00100, 4'h8);
        chk("wait4_valid", bus.all_valid, 0);
        press(5'b01000, 4'h8);
        press(5'b10000, 4'h8);
        chk("full_op",     bus.op_bus,    20'h88858);
        chk("full_loaded", bus.loaded,    5'b11111);
        chk("full_valid",  bus.all_valid, 1);
        chk("full_err",    bus.err_order, 0);

        // Press in FULL: flagged, operands held.
        press(5'b00010, 4'hF);
        chk("fullpress_err",    bus.err_order, 1);
        chk("fullpress_op",     bus.op_bus,    20'h88858);
        chk("fullpress_loaded", bus.loaded,    5'b11111);
        chk("fullpress_valid",  bus.all_valid, 1);

        do_clear();
        chk("clear_op",     bus.op_bus,    0);
        chk("clear_loaded", bus.loaded,    0);
        chk("clear_valid",  bus.all_valid, 0);
        chk("clear_err",    bus.err_order, 0);
        press(5'b00001, 4'h3);
        chk("after_clear_op",     bus.op_bus, 20'h00003);
        chk("after_clear_loaded", bus.loaded, 5'b00001);
        chk("after_clear_err",    bus.err_order, 0);

        // Out of order in WAIT1, then in-order recovery.
        do_clear();
        press(5'b00100, 4'h8);
        chk("ooo_err",    bus.err_order, 1);
        chk("ooo_loaded", bus.loaded,    0);
        chk("ooo_op",     bus.op_bus,    0);
        press(5'b00001, 4'h3);
        chk("ooo_pb1_op",     bus.op_bus,    20'h00003);
        chk("ooo_pb1_loaded", bus.loaded,    5'b00001);
        chk("ooo_pb1_err",    bus.err_order, 1);
        press(5'b00010, 4'h6);
        chk("ooo_pb2_op",     bus.op_bus, 20'h00063);
        chk("ooo_pb2_loaded", bus.loaded, 5'b00011);

        // Simultaneous PB1+PB2 in WAIT1: PB1 accepted, error flagged.
        do_clear();
        press(5'b00011, 4'h9);
        chk("simul_op",     bus.op_bus,    20'h00009);
        chk("simul_loaded", bus.loaded,    5'b00001);
        chk("simul_err",    bus.err_order, 1);

        // Clear in the pulse cycle discards the press; holding gives no repeat.
        do_clear();
        bus.pb = 5'b00001;
        bus.y  = 4'h7;
        wait_pulse(n);
        chk("clrpulse_latency", n, 7);
        do_clear();
        chk("clrpulse_loaded", bus.loaded, 0);
        chk("clrpulse_op",     bus.op_bus, 0);
        repeat (10) tick();
        chk("clrpulse_hold_loaded", bus.loaded, 0);
        bus.pb = '0;
        repeat (8) tick();

        // rst and clear in a pulse cycle; held button re-pulses after reset.
        bus.pb = 5'b00001;
        bus.y  = 4'hA;
        wait_pulse(n);
        chk("rstpulse_latency", n, 7);
        rst       = 1'b1;
        bus.clear = 1'b1;
        tick();
        rst       = 1'b0;
        bus.clear = 1'b0;
        chk("rstpri_pulse",  bus.pb_pulse,  0);
        chk("rstpri_loaded", bus.loaded,    0);
        chk("rstpri_op",     bus.op_bus,    0);
        chk("rstpri_valid",  bus.all_valid, 0);
        chk("rstpri_err",    bus.err_order, 0);
        wait_pulse(n);
        chk("rst_repulse_latency", n, 7);
        chk("rst_repulse_value",   bus.pb_pulse, 5'b00001);
        tick();
        chk("rst_capture_op",     bus.op_bus, 20'h0000A);
        chk("rst_capture_loaded", bus.loaded, 5'b00001);
        bus.pb = '0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
